fetch_unit: RTL

Instruction fetch stage directly upstream of the instruction decoder. Holds the program counter and fetches 32-bit words from instruction memory over a req/ack handshake. Buffers fetched words with their addresses in a small FIFO and presents them to the decoder under a valid/ready handshake. Applies taken branches by flushing buffered and in-flight words and redirecting the PC to `PC+8+(sext(imm24)<<2)`.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/fetch_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types, constants and the branch-target helper for the fetch stage.
package fetch_pkg;

  localparam int          INSTR_W        = 32;
  localparam logic [31:0] PC_PIPE_OFFSET = 32'd8;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    IDLE = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // The branch offset counts words relative to the pipelined PC (pc + 8); wraps modulo 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [23:0] imm24);
    return pc + PC_PIPE_OFFSET + {{6{imm24[23]}}, imm24, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of {pc, instr} entries; the head is read directly from storage flops,
// so nothing on the write side reaches the outputs combinationally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [2*INSTR_W-1:0] wdata,
  output logic [2*INSTR_W-1:0] head,
  output logic                 valid,
  output logic [CNT_W-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 2 * INSTR_W;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  // Next-state for storage, pointers and occupancy; flush wins over push and pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pop_ok   = pop & (count_q != '0);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign valid = (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding memory request FSM, branch redirect
// and a small buffer feeding the decoder.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_ack,
  input  logic [INSTR_W-1:0]   imem_rdata,
  output logic [INSTR_W-1:0]   instr_out,
  output logic [31:0]          pc_out,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 branch_en,
  input  logic [23:0]          branch_imm
);

  localparam int          CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

  fetch_state_t         state_q, state_d;
  logic [31:0]          fetch_pc_q, fetch_pc_d;
  logic [31:0]          tgt_q, tgt_d;
  logic                 req_q, req_d;
  logic [31:0]          tgt_s;
  logic                 pop_s, take_s, ack_s, push_s, flush_s, fills_s;
  logic [CNT_W-1:0]     count_s;
  logic [2*INSTR_W-1:0] head_s;

  assign pop_s   = instr_valid & instr_ready;
  assign take_s  = pop_s & branch_en;
  // An ack only counts while a request is actually being presented.
  assign ack_s   = imem_ack & req_q;
  assign tgt_s   = branch_target(pc_out, branch_imm);
  assign fills_s = ~pop_s & (count_s == CNT_W'(FIFO_DEPTH - 1));

  // Request FSM next-state, PC update and FIFO control.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    tgt_d      = tgt_q;
    push_s     = 1'b0;
    flush_s    = 1'b0;
    case (state_q)
      REQ: begin
        if (take_s) begin
          flush_s = 1'b1;
          if (ack_s) begin
            fetch_pc_d = tgt_s;
            state_d    = REQ;
          end else begin
            tgt_d   = tgt_s;
            state_d = DROP;
          end
        end else if (ack_s) begin
          push_s     = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = fills_s ? IDLE : REQ;
        end else begin
          state_d = REQ;
        end
      end
      IDLE: begin
        if (take_s) begin
          flush_s    = 1'b1;
          fetch_pc_d = tgt_s;
          state_d    = REQ;
        end else if (pop_s) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      DROP: begin
        // The old request cannot be withdrawn; wait for its ack and throw the word away.
        if (ack_s) begin
          fetch_pc_d = tgt_q;
          state_d    = REQ;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
    req_d = (state_d != IDLE);
  end

  // FSM and PC registers; req is registered so it rises one cycle after reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REQ;
      fetch_pc_q <= START_PC;
      tgt_q      <= START_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      tgt_q      <= tgt_d;
      req_q      <= req_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush_s),
    .wdata ({fetch_pc_q, imem_rdata}),
    .head  (head_s),
    .valid (instr_valid),
    .count (count_s)
  );

  assign imem_req  = req_q;
  assign imem_addr = fetch_pc_q;
  assign pc_out    = head_s[2*INSTR_W-1:INSTR_W];
  assign instr_out = head_s[INSTR_W-1:0];

endmodule
